// File: rtl/nibble_add_sequencer_pkg.sv
// Shared types and constants for the nibble-serial adder.
// SUB_MODE_EN (optional macro) adds a subtract control input.
package nibble_add_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   function automatic int idx_w(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// SUB_MODE_EN adds in_sub to the operand side.
interface nibble_add_sequencer_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
`ifdef SUB_MODE_EN
   logic             in_sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             busy;

`ifdef SUB_MODE_EN
   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );
   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );
`else
   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );
   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
   );
`endif

endinterface

// File: rtl/nibble_add_sequencer_cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Shared by every nibble position of the sequencer.
module cla4_slice
   import nibble_add_sequencer_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign p = a ^ b;
   assign g = a & b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: one CLA nibble per clock, LSB first.
// SUB_MODE_EN enables subtract via in_sub (a + ~b + 1).
module nibble_add_sequencer
   import nibble_add_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nibble_add_sequencer_if.slave bus
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IW      = idx_w(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   state_t           state;
   logic [IW-1:0]    idx;
   logic             cy;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [NIBBLE_W-1:0] s_a;
   logic [NIBBLE_W-1:0] s_b;
   logic [NIBBLE_W-1:0] s_sum;
   logic                s_cout;
   logic [WIDTH-1:0]    b_eff;
   logic                cin_eff;

`ifdef SUB_MODE_EN
   assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
   assign cin_eff = bus.in_sub | bus.in_cin;
`else
   assign b_eff   = bus.in_b;
   assign cin_eff = bus.in_cin;
`endif

   assign s_a = a_q[NIBBLE_W*idx +: NIBBLE_W];
   assign s_b = b_q[NIBBLE_W*idx +: NIBBLE_W];

   cla4_slice u_slice (
      .a    (s_a),
      .b    (s_b),
      .cin  (cy),
      .sum  (s_sum),
      .cout (s_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         cy     <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.in_a;
                  b_q   <= b_eff;
                  cy    <= cin_eff;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum_q[NIBBLE_W*idx +: NIBBLE_W] <= s_sum;
               cy  <= s_cout;
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  cout_q <= s_cout;
                  // top slice sum bit is the result MSB
                  ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                         && (s_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                  state  <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == RUN);
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench for nibble_add_sequencer at WIDTH=16.
// Define SUB_MODE_EN for both RTL and bench to cover subtract mode.
module tb_nibble_add_sequencer;

   localparam int W  = 16;
   localparam int NB = W / 4;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      res_t         exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   res_t sb[$];

   always #5 clk = ~clk;

   nibble_add_sequencer_if #(.WIDTH(W)) bus ();

   nibble_add_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic res_t model(input logic [W-1:0] a, b,
                                  input logic cin, sub);
      logic [W-1:0] be;
      logic         c0;
      logic [W:0]   full;
      res_t         r;
      be   = sub ? ~b : b;
      c0   = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] a, b,
                        input logic cin, sub);
      bus.in_a   = a;
      bus.in_b   = b;
      bus.in_cin = cin;
`ifdef SUB_MODE_EN
      bus.in_sub = sub;
`else
      if (sub) $display("note: sub ignored without SUB_MODE_EN");
`endif
   endtask

   // accept one operation, wait for DONE, leave result presented
   task automatic issue(input logic [W-1:0] a, b,
                        input logic cin, sub, input res_t exp);
      int n;
      n = 0;
      drive(a, b, cin, sub);
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 20) begin
         step();
         n++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 32'd1);
      sb.push_back(exp);
      step();
      bus.in_valid = 1'b0;
      check("busy_in_run", 32'(bus.busy), 32'd1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         step();
         n++;
      end
      check("latency_edges", 32'(n + 1), 32'(NB + 1));
   endtask

   task automatic compare_result(input string tag);
      res_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({tag, "_sum"},  32'(bus.out_sum),  32'(e.sum));
      check({tag, "_cout"}, 32'(bus.out_cout), 32'(e.cout));
      check({tag, "_ovf"},  32'(bus.out_ovf),  32'(e.ovf));
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("rel_out_valid", 32'(bus.out_valid), 32'd0);
      check("rel_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   vec_t vecs[$];

   initial begin
      res_t held;
      logic [W-1:0] ra, rb;
      logic         rc;

      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0,
                       '{16'h5555, 1'b0, 1'b0}});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0,
                       '{16'h0000, 1'b1, 1'b0}});
      vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0,
                       '{16'h8000, 1'b0, 1'b1}});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0,
                       '{16'h0000, 1'b1, 1'b1}});
      vecs.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0,
                       '{16'h1001, 1'b0, 1'b0}});
`ifdef SUB_MODE_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1,
                       '{16'hFFFE, 1'b0, 1'b0}});
      vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1,
                       '{16'h0002, 1'b1, 1'b0}});
`endif

      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      repeat (3) step();
      rst_n = 1'b1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_sum", 32'(bus.out_sum), 32'd0);

      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].cin,
               vecs[i].sub, vecs[i].exp);
         compare_result($sformatf("vec%0d", i));
         release_result();
      end

      for (int k = 0; k < 12; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(1));
         issue(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
         compare_result("rand");
         release_result();
      end

      // consumer stalls in DONE while a new request is offered
      issue(16'h00FF, 16'h0101, 1'b0, 1'b0,
            model(16'h00FF, 16'h0101, 1'b0, 1'b0));
      held = '{bus.out_sum, bus.out_cout, bus.out_ovf};
      compare_result("hold");
      drive(16'hAAAA, 16'h5555, 1'b1, 1'b0);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_sum", 32'(bus.out_sum), 32'h0200);
      end
      bus.in_valid = 1'b0;
      release_result();
      step();
      check("hold_no_accept", 32'(bus.busy), 32'd0);
      check("hold_sum_kept", 32'(bus.out_sum), 32'(held.sum));

      // reset in the middle of RUN
      issue(16'h1111, 16'h2222, 1'b0, 1'b0, '0);
      void'(sb.pop_front());
      release_result();
      drive(16'h9999, 16'h9999, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      check("mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("mrst_sum", 32'(bus.out_sum), 32'd0);
      check("mrst_cout", 32'(bus.out_cout), 32'd0);

      issue(16'h1234, 16'h4321, 1'b0, 1'b0,
            model(16'h1234, 16'h4321, 1'b0, 1'b0));
      compare_result("post_rst");
      release_result();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
